// File: rtl/vend_controller.sv
// +--------------------------------------------------------------------------+
// | Module  : vend_controller                                                |
// | Brief   : Clocked vending front end: credit, price/stock, vend & change. |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module vend_controller #(
  parameter int NUM_SLOTS     = 9,
  parameter int CREDIT_W      = 12,
  parameter int STOCK_W       = 4,
  parameter int MAX_CREDIT    = 2000,
  parameter int DEFAULT_PRICE = 125,
  parameter int DEFAULT_STOCK = 5,
  parameter int PRICE_HOLD    = 200000000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sel_valid,
  input  logic [$clog2(NUM_SLOTS)-1:0] sel_idx,
  input  logic                         coin_valid,
  input  logic [2:0]                   coin_type,
  input  logic                         cancel,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_SLOTS)-1:0] cfg_idx,
  input  logic [CREDIT_W-1:0]          cfg_price,
  input  logic [STOCK_W-1:0]           cfg_stock,
  output logic [NUM_SLOTS-1:0]         avail_led,
  output logic [NUM_SLOTS-1:0]         oos_led,
  output logic [CREDIT_W-1:0]          disp_value,
  output logic [1:0]                   disp_mode,
  output logic                         vend_valid,
  output logic [$clog2(NUM_SLOTS)-1:0] vend_idx,
  input  logic                         vend_ready,
  output logic                         chg_valid,
  output logic [2:0]                   chg_type,
  input  logic                         chg_ready,
  output logic                         coin_reject,
  output logic                         busy
);

  localparam int IDX_W  = $clog2(NUM_SLOTS);
  localparam int HOLD_W = $clog2(PRICE_HOLD + 1);
  localparam logic [CREDIT_W:0]  c_maxCredit = MAX_CREDIT[CREDIT_W:0];
  localparam logic [HOLD_W-1:0]  c_holdLoad  = HOLD_W'(PRICE_HOLD);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CREDIT = 2'd1,
    S_VEND   = 2'd2,
    S_CHANGE = 2'd3
  } state_t;

  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] r_vendPrice;
  logic [HOLD_W-1:0]   r_holdCnt;
  logic [CREDIT_W-1:0] r_price [NUM_SLOTS];
  logic [STOCK_W-1:0]  r_stock [NUM_SLOTS];

  state_t              w_nState;
  logic [CREDIT_W-1:0] w_nCredit;
  logic [HOLD_W-1:0]   w_nHold;
  logic                w_nReject;
  logic                w_vendGo;
  logic                w_vendDone;
  logic                w_query;
  logic [CREDIT_W-1:0] w_coinVal;
  logic [CREDIT_W:0]   w_coinSum;
  logic                w_coinOk;
  logic                w_selOk;
  logic [CREDIT_W-1:0] w_selPrice;
  logic [STOCK_W-1:0]  w_selStock;

  function automatic logic [CREDIT_W-1:0] coinValue(input logic [2:0] t);
    case (t)
      3'd0:    return CREDIT_W'(5);
      3'd1:    return CREDIT_W'(10);
      3'd2:    return CREDIT_W'(25);
      3'd3:    return CREDIT_W'(50);
      3'd4:    return CREDIT_W'(100);
      3'd5:    return CREDIT_W'(500);
      default: return '0;
    endcase
  endfunction

  // Largest coin not exceeding the remaining credit; ends on 5c for any multiple of 5.
  function automatic logic [2:0] greedyCoin(input logic [CREDIT_W-1:0] c);
    if (c >= CREDIT_W'(500))      return 3'd5;
    else if (c >= CREDIT_W'(100)) return 3'd4;
    else if (c >= CREDIT_W'(50))  return 3'd3;
    else if (c >= CREDIT_W'(25))  return 3'd2;
    else if (c >= CREDIT_W'(10))  return 3'd1;
    else                          return 3'd0;
  endfunction

  always_comb begin
    w_coinVal  = coinValue(coin_type);
    w_coinSum  = {1'b0, r_credit} + {1'b0, w_coinVal};
    w_coinOk   = (coin_type <= 3'd5) && (w_coinSum <= c_maxCredit);
    w_selOk    = sel_valid && (32'(sel_idx) < NUM_SLOTS);
    w_selPrice = w_selOk ? r_price[sel_idx] : '0;
    w_selStock = w_selOk ? r_stock[sel_idx] : '0;

    w_nState   = r_state;
    w_nCredit  = r_credit;
    w_nHold    = (r_holdCnt != '0) ? r_holdCnt - HOLD_W'(1) : '0;
    w_nReject  = 1'b0;
    w_vendGo   = 1'b0;
    w_vendDone = 1'b0;
    w_query    = 1'b0;

    case (r_state)
      S_IDLE, S_CREDIT: begin
        if (cancel) begin
          w_nReject = coin_valid;
          w_nHold   = '0;
          if (r_state == S_CREDIT) w_nState = S_CHANGE;
        end else if (coin_valid) begin
          w_nHold = '0;
          if (w_coinOk) begin
            w_nCredit = w_coinSum[CREDIT_W-1:0];
            w_nState  = S_CREDIT;
          end else begin
            w_nReject = 1'b1;
          end
        end else if (w_selOk) begin
          if (r_state == S_CREDIT && w_selStock != '0 && r_credit >= w_selPrice) begin
            w_nState = S_VEND;
            w_vendGo = 1'b1;
            w_nHold  = '0;
          end else begin
            w_query = 1'b1;
            w_nHold = c_holdLoad;
          end
        end
      end
      S_VEND: begin
        w_nReject = coin_valid;
        if (vend_ready) begin
          w_vendDone = 1'b1;
          w_nCredit  = r_credit - r_vendPrice;
          w_nState   = (w_nCredit != '0) ? S_CHANGE : S_IDLE;
        end
      end
      S_CHANGE: begin
        w_nReject = coin_valid;
        if (chg_ready) begin
          w_nCredit = r_credit - coinValue(chg_type);
          w_nState  = (w_nCredit != '0) ? S_CHANGE : S_IDLE;
        end
      end
      default: w_nState = S_IDLE;
    endcase
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_led
    assign oos_led[i]   = (r_stock[i] == '0);
    assign avail_led[i] = (r_stock[i] != '0) && (r_credit >= r_price[i]) && (r_state == S_CREDIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_credit    <= '0;
      r_vendPrice <= '0;
      r_holdCnt   <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_price[i] <= CREDIT_W'(DEFAULT_PRICE);
        r_stock[i] <= STOCK_W'(DEFAULT_STOCK);
      end
      vend_valid  <= 1'b0;
      vend_idx    <= '0;
      chg_valid   <= 1'b0;
      chg_type    <= 3'd0;
      coin_reject <= 1'b0;
      disp_mode   <= 2'b00;
      disp_value  <= '0;
      busy        <= 1'b0;
    end else begin
      r_state     <= w_nState;
      r_credit    <= w_nCredit;
      r_holdCnt   <= w_nHold;
      coin_reject <= w_nReject;
      if (w_vendGo) begin
        vend_idx    <= sel_idx;
        r_vendPrice <= w_selPrice;
      end
      // Configuration is applied after the decrement so a same-slot write wins.
      if (w_vendDone) r_stock[vend_idx] <= r_stock[vend_idx] - STOCK_W'(1);
      if (cfg_we && 32'(cfg_idx) < NUM_SLOTS) begin
        r_price[cfg_idx] <= cfg_price;
        r_stock[cfg_idx] <= cfg_stock;
      end
      vend_valid <= (w_nState == S_VEND);
      chg_valid  <= (w_nState == S_CHANGE);
      chg_type   <= greedyCoin(w_nCredit);
      busy       <= (w_nState == S_VEND) || (w_nState == S_CHANGE);
      if (w_nState == S_CHANGE) begin
        disp_mode  <= 2'b10;
        disp_value <= w_nCredit;
      end else if (w_query) begin
        disp_mode  <= 2'b01;
        disp_value <= w_selPrice;
      end else if (w_nHold != '0) begin
        disp_mode  <= 2'b01;
      end else begin
        disp_mode  <= 2'b00;
        disp_value <= w_nCredit;
      end
    end
  end

endmodule

`default_nettype wire
